// File: rtl/ter_inv_arbiter_if.sv
// ---------------------------------------------------------------------------
// ter_inv_arbiter_if
// Request/response bundle for ter_inv_arbiter.
//   TRITS      : trits per word; data buses are 2*TRITS bits, trit k at [2k+1:2k]
//   req0_*     : requester 0 valid/data/ready handshake
//   req1_*     : requester 1 valid/data/ready handshake
//   rsp_*      : inverted word, owning requester id, valid/ready handshake
// Modports: slave = arbiter side, master = requesters/consumer side.
// ---------------------------------------------------------------------------
interface ter_inv_arbiter_if #(
   parameter int unsigned TRITS = 4
);
   logic                 req0_valid;
   logic [2*TRITS-1:0]   req0_data;
   logic                 req0_ready;
   logic                 req1_valid;
   logic [2*TRITS-1:0]   req1_data;
   logic                 req1_ready;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [2*TRITS-1:0]   rsp_data;
   logic                 rsp_id;

   modport slave (
      input  req0_valid, req0_data,
      output req0_ready,
      input  req1_valid, req1_data,
      output req1_ready,
      output rsp_valid, rsp_data, rsp_id,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_data,
      input  req0_ready,
      output req1_valid, req1_data,
      input  req1_ready,
      input  rsp_valid, rsp_data, rsp_id,
      output rsp_ready
   );
endinterface

// File: rtl/ter_inv_arbiter.sv
// ---------------------------------------------------------------------------
// ter_inv_arbiter
// Two-requester arbiter in front of a single serial balanced-ternary inverter.
// A granted word is latched, inverted one trit per cycle (LSB trit first)
// through one shared trit inverter, then presented on the response channel
// until the consumer accepts it. Round-robin priority flips to the requester
// not just served.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ter_inv_arbiter_if.slave (req0/req1/rsp handshakes)
//   busy   : high whenever the FSM is not IDLE
//   err    : (only with TER_INV_INVALID_CHECK_EN) word held in DONE contained
//            an invalid trit (2'b11); valid with rsp_valid
//
// Configuration macro: TER_INV_INVALID_CHECK_EN
//   undefined : no err port, 2'b11 trits pass through unchanged
//   defined   : adds the err output and the invalid-trit check
// ---------------------------------------------------------------------------
module ter_inv_arbiter #(
   parameter int unsigned TRITS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   ter_inv_arbiter_if.slave  bus,
   output logic              busy
`ifdef TER_INV_INVALID_CHECK_EN
   ,
   output logic              err
`endif
);

   localparam int unsigned CW = (TRITS > 1) ? $clog2(TRITS) : 1;
   localparam int unsigned DW = 2 * TRITS;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CW-1:0] LAST = CW'(TRITS - 1);

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_prio;
   logic          r_id;
   logic [DW-1:0] r_word;
   logic [DW-1:0] r_result;

   logic          w_gnt;
   logic          w_hs;
   logic [1:0]    w_trit;
   logic [1:0]    w_inv;

   // Grant: a lone requester wins; with both valid the priority pointer decides.
   always_comb begin
      w_gnt = r_prio;
      if (bus.req0_valid && !bus.req1_valid)
         w_gnt = 1'b0;
      else if (bus.req1_valid && !bus.req0_valid)
         w_gnt = 1'b1;
   end

   // Readys are gated by rst_n so they drop the instant reset asserts,
   // not just once the state register has been cleared.
   assign bus.req0_ready = rst_n && (r_state == S_IDLE) && bus.req0_valid && !w_gnt;
   assign bus.req1_ready = rst_n && (r_state == S_IDLE) && bus.req1_valid &&  w_gnt;
   assign w_hs           = bus.req0_ready || bus.req1_ready;

   // Shared trit inverter: select trit[cnt], swapping the two bits maps
   // 01<->10 and leaves 00 and 11 unchanged.
   always_comb begin
      w_trit = 2'b00;
      for (int unsigned k = 0; k < TRITS; k++) begin
         if (r_cnt == CW'(k))
            w_trit = r_word[2*k +: 2];
      end
      w_inv = {w_trit[0], w_trit[1]};
   end

`ifdef TER_INV_INVALID_CHECK_EN
   logic w_any_invalid;
   logic r_err;

   always_comb begin
      w_any_invalid = 1'b0;
      for (int unsigned k = 0; k < TRITS; k++) begin
         if (r_word[2*k +: 2] == 2'b11)
            w_any_invalid = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if ((r_state == S_RUN) && (r_cnt == LAST)) begin
         r_err <= w_any_invalid;
      end else if ((r_state == S_DONE) && bus.rsp_ready) begin
         r_err <= 1'b0;
      end
   end

   assign err = r_err;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_prio   <= 1'b0;
         r_id     <= 1'b0;
         r_word   <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_word  <= w_gnt ? bus.req1_data : bus.req0_data;
                  r_id    <= w_gnt;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               for (int unsigned k = 0; k < TRITS; k++) begin
                  if (r_cnt == CW'(k))
                     r_result[2*k +: 2] <= w_inv;
               end
               if (r_cnt == LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (bus.rsp_ready) begin
                  r_prio  <= ~r_id;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.rsp_valid = (r_state == S_DONE);
   assign bus.rsp_data  = (r_state == S_DONE) ? r_result : '0;
   assign bus.rsp_id    = (r_state == S_DONE) ? r_id : 1'b0;
   assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_ter_inv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ter_inv_arbiter
// Directed bench for ter_inv_arbiter with TRITS=4. Expected words are
// hand-computed inversions; latency is counted in cycles after the handshake.
// ---------------------------------------------------------------------------
module tb_ter_inv_arbiter;

   localparam int unsigned TRITS = 4;

   logic clk;
   logic rst_n;
   logic busy;
`ifdef TER_INV_INVALID_CHECK_EN
   logic err;
`endif

   int n_checks = 0;
   int n_errors = 0;

   ter_inv_arbiter_if #(.TRITS(TRITS)) bus ();

   ter_inv_arbiter #(.TRITS(TRITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
`ifdef TER_INV_INVALID_CHECK_EN
      ,
      .err   (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Counts cycles from the handshake edge until rsp_valid, bounded.
   task automatic wait_rsp(input string tag, output int cyc);
      int edges;
      edges = 0;
      cyc   = 0;
      forever begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            cyc = edges + 1;
            break;
         end
         if (edges >= 20) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            break;
         end
         @(posedge clk);
         edges++;
      end
   endtask

   // Called at posedge+1 right after the handshake edge; returns at the
   // negedge of the first DONE cycle.
   task automatic expect_rsp(input string tag, input logic [7:0] exp_data,
                             input logic exp_id, input logic exp_err);
      int cyc;
      wait_rsp(tag, cyc);
      chk({tag, "_lat"},  32'(cyc), 32'd5);
      chk({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_data));
      chk({tag, "_id"},   32'(bus.rsp_id), 32'(exp_id));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
`ifdef TER_INV_INVALID_CHECK_EN
      chk({tag, "_err"},  32'(err), 32'(exp_err));
`else
      if (exp_err) begin end
`endif
   endtask

   // Offer a word on one requester and complete the handshake.
   task automatic handshake(input string tag, input logic which, input logic [7:0] data);
      if (which) begin
         bus.req1_valid = 1'b1;
         bus.req1_data  = data;
      end else begin
         bus.req0_valid = 1'b1;
         bus.req0_data  = data;
      end
      @(negedge clk);
      chk({tag, "_rdy"}, 32'(which ? bus.req1_ready : bus.req0_ready), 32'd1);
      @(posedge clk);
      #1;
      if (which) bus.req1_valid = 1'b0;
      else       bus.req0_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'h96;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'h04;
      bus.rsp_ready  = 1'b1;

      // Reset state, with both requesters already valid.
      #12;
      chk("rst_rdy0",  32'(bus.req0_ready), 32'd0);
      chk("rst_rdy1",  32'(bus.req1_ready), 32'd0);
      chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_data",  32'(bus.rsp_data), 32'd0);
      chk("rst_id",    32'(bus.rsp_id), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      do_reset();

      // Single request: 96 -> 69, one-cycle response with rsp_ready high.
      handshake("t1", 1'b0, 8'h96);
      @(negedge clk);
      chk("t1_run_rdy1", 32'(bus.req1_ready), 32'd0);
      @(posedge clk);
      #1;
      // expect_rsp counts from the handshake edge; one RUN cycle already spent
      // above, so re-run a fresh transaction for the latency measurement.
      expect_rsp_skip();
      @(posedge clk);
      #1;
      handshake("t1b", 1'b0, 8'h96);
      expect_rsp("t1b", 8'h69, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t1_after_valid", 32'(bus.rsp_valid), 32'd0);
      chk("t1_after_busy",  32'(busy), 32'd0);

      // Both valid after reset: req0 first, then req1; pointer returns to 0.
      do_reset();
      bus.req0_valid = 1'b1;
      bus.req0_data  = 8'h01;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'h04;
      @(negedge clk);
      chk("t2_rdy0", 32'(bus.req0_ready), 32'd1);
      chk("t2_rdy1", 32'(bus.req1_ready), 32'd0);
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      expect_rsp("t2a", 8'h02, 1'b0, 1'b0);
      chk("t2a_done_rdy1", 32'(bus.req1_ready), 32'd0);
      @(posedge clk);
      #1;
      handshake("t2b", 1'b1, 8'h04);
      expect_rsp("t2b", 8'h08, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      @(negedge clk);
      chk("t2_prio_rdy0", 32'(bus.req0_ready), 32'd1);
      chk("t2_prio_rdy1", 32'(bus.req1_ready), 32'd0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t2_nolatch_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      // Invalid trit passes through: 1B -> 27.
      handshake("t3", 1'b0, 8'h1B);
      expect_rsp("t3", 8'h27, 1'b0, 1'b1);
      @(posedge clk);
      #1;

      // Back-pressure: DONE held for 10 cycles, req1 ignored meanwhile.
      bus.rsp_ready = 1'b0;
      handshake("t4", 1'b0, 8'h96);
      expect_rsp("t4", 8'h69, 1'b0, 1'b0);
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'h01;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("t4_hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("t4_hold_data",  32'(bus.rsp_data), 32'h69);
         chk("t4_hold_id",    32'(bus.rsp_id), 32'd0);
         chk("t4_hold_rdy0",  32'(bus.req0_ready), 32'd0);
         chk("t4_hold_rdy1",  32'(bus.req1_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t4_rel_rdy1", 32'(bus.req1_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.req1_valid = 1'b0;
      expect_rsp("t4b", 8'h02, 1'b1, 1'b0);
      @(posedge clk);
      #1;

      // Reset in the 2nd RUN cycle discards the word in flight.
      handshake("t5", 1'b0, 8'h96);
      @(posedge clk);
      #2;
      bus.req1_valid = 1'b1;
      bus.req1_data  = 8'h04;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy",  32'(busy), 32'd0);
      chk("t5_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("t5_rst_data",  32'(bus.rsp_data), 32'd0);
      chk("t5_rst_id",    32'(bus.rsp_id), 32'd0);
      chk("t5_rst_rdy0",  32'(bus.req0_ready), 32'd0);
      chk("t5_rst_rdy1",  32'(bus.req1_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t5_post_rdy1", 32'(bus.req1_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.req1_valid = 1'b0;
      expect_rsp("t5b", 8'h08, 1'b1, 1'b0);
      @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Drains the first t1 transaction (latency measured on the repeat).
   task automatic expect_rsp_skip();
      int cyc;
      wait_rsp("t1", cyc);
      chk("t1_data", 32'(bus.rsp_data), 32'h69);
      chk("t1_id",   32'(bus.rsp_id), 32'd0);
   endtask

endmodule

// File: doc/ter_inv_arbiter.md
TER_INV_ARBITER -- requirements
Module: ter_inv_arbiter

Interface
REQ-001 SHALL have parameter TRITS, default 4, number of trits per word (range 1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req0_valid  input  1  requester 0 offers a word.
REQ-005 SHALL have port req0_data  input  2*TRITS  requester 0 word; trit k in bits [2k+1:2k].
REQ-006 SHALL have port req0_ready  output  1  requester 0 word accepted this cycle.
REQ-007 SHALL have ports req1_valid, req1_data, req1_ready, identical to REQ-004..006, for requester 1.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-010 SHALL have port rsp_data  output  2*TRITS  inverted word.
REQ-011 SHALL have port rsp_id  output  1  requester that owns rsp_data.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 Trit encoding SHALL be: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1, 2'b11 = invalid.
REQ-014 Per-trit inversion SHALL map 01->10, 10->01, 00->00, 11->11.
REQ-015 SHALL use one shared trit inverter, applied to one trit per cycle, LSB trit first.
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 IDLE: reqX_ready SHALL be combinational, high only for the granted requester while that requester's valid is high.
REQ-018 Grant rule: with one valid, grant that one; with both valid, grant the requester named by the priority pointer prio.
REQ-019 On a handshake the word and the grant id SHALL be latched, the trit counter cleared, and the FSM SHALL move IDLE->RUN.
REQ-020 RUN: each cycle SHALL write the inverted trit[cnt] into the result register and increment cnt; at cnt==TRITS-1 the FSM SHALL move to DONE.
REQ-021 DONE: rsp_valid=1, with rsp_data and rsp_id held stable until rsp_ready.
REQ-022 On rsp_valid&&rsp_ready the FSM SHALL move to IDLE and prio SHALL be set to the requester not just served.
REQ-023 Latency: the handshake in cycle 0 SHALL give rsp_valid in cycle TRITS+1.
REQ-024 No request SHALL be accepted outside IDLE; both reqX_ready SHALL be 0 in RUN and DONE.
REQ-025 A requester dropping valid before its grant SHALL lose nothing; no request is latched without a handshake.
REQ-026 Back-pressure: the FSM SHALL stay in DONE for any number of cycles while rsp_ready is low.
REQ-027 Maximum throughput SHALL be one word per TRITS+2 cycles, with rsp_ready tied high.

Reset
REQ-028 rst_n low SHALL immediately give: state IDLE, cnt=0, prio=0, result=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, both readys=0 (err=0 when present).
REQ-029 Reset mid-RUN or mid-DONE SHALL discard the word in flight, and no response SHALL be produced for it.
REQ-030 The first edge after deassertion SHALL be able to accept a request.

Configuration
REQ-031 Macro TER_INV_INVALID_CHECK_EN defined: SHALL add port err  output  1.
  - err is set in DONE when any latched trit was 2'b11.
  - err is valid with rsp_valid and cleared on leaving DONE.
REQ-032 TER_INV_INVALID_CHECK_EN undefined: there SHALL be no err port and no check logic; 2'b11 passes through unchanged.

Verification (TRITS=4)
REQ-033 req0 only, data 8'h96, rsp_ready=1 -> rsp_data=8'h69, rsp_id=0, rsp_valid in cycle 5 after handshake, held 1 cycle.
REQ-034 req0 and req1 both valid after reset, data 8'h01 and 8'h04 -> first rsp_id=0 with 8'h02, then rsp_id=1 with 8'h08; prio ends at 0.
REQ-035 Data 8'h1B with macro defined -> rsp_data=8'h27, err=1; with macro undefined -> rsp_data=8'h27, no err port.
REQ-036 rsp_ready held low 10 cycles in DONE -> rsp_valid, rsp_data and rsp_id stable, both readys 0, req1_valid ignored until release.
REQ-037 rst_n pulsed low in the 2nd RUN cycle -> all outputs 0 asynchronously, no rsp_valid for that word, next request served normally.
